rf_wport_arbiter: RTL and testbench

Arbiter and sequencer for the single general-register-file write port. It shares the port between two requesters: the in-order writeback stage, which has priority, and the long-latency unit completion path (divider/multiplier results), which is captured in a one-entry holding buffer. The arbiter registers the winning write toward the register file, the ID-stage forwarding bus and the debug trace. A starvation guard can stall writeback so the buffer always drains.

---
 rtl/rf_wport_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_rf_wport_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
// Shares the single general-register-file write port between two requesters:
//   - the in-order writeback stage (normally wins),
//   - the long-latency unit completion path, captured in a one-entry buffer.
// The winning write is registered once and fanned out to the register file,
// the ID-stage forwarding bus and the debug trace port.
//
// Optional feature (compile-time macro RF_ARB_STARVE_EN):
//   defined   -> a starvation counter forces the buffered entry through after
//                STARVE_MAX consecutive lost cycles by stalling writeback.
//   undefined -> no counter; wb_ready is constant 1 and the buffer drains only
//                in cycles without a writeback register write.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   wb_valid/we/dest/wdata/pc, wb_ready   writeback request and acceptance
//   lu_valid/dest/wdata/pc, lu_ready      long-latency valid/ready handshake
//   rf_we/rf_waddr/rf_wdata                registered register-file write
//   fwd_bus                                {rf_we, rf_waddr, rf_wdata}
//   debug_wb_pc/rf_we/rf_wnum/rf_wdata     registered debug trace
module rf_wport_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_we,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_wdata,
    input  logic [31:0] wb_pc,
    output logic        wb_ready,
    input  logic        lu_valid,
    input  logic [4:0]  lu_dest,
    input  logic [31:0] lu_wdata,
    input  logic [31:0] lu_pc,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [37:0] fwd_bus,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_starve_max_check
        $error("rf_wport_arbiter: STARVE_MAX must be in 1..7");
    end

    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t  state, state_nxt;
    logic [4:0]  buf_dest;
    logic [31:0] buf_wdata;
    logic [31:0] buf_pc;
    logic        buf_dead;     // captured alongside a same-dest writeback: never written

    logic        wb_use;
    logic        buf_live;
    logic        lu_fire;
    logic        force_buf;
    logic        grant_wb;
    logic        grant_buf;
    logic        squash;
    logic [31:0] rf_pc;

    assign wb_use   = wb_valid && wb_we && (wb_dest != 5'd0);
    assign buf_live = (state == FULL) && !buf_dead;
    // Ready comes from registered state only, so there is no lu_valid -> lu_ready path.
    assign lu_ready = (state == EMPTY) && !reset;
    assign lu_fire  = lu_valid && lu_ready;

`ifdef RF_ARB_STARVE_EN
    localparam logic [2:0] STARVE_LIMIT = 3'(STARVE_MAX);

    logic [2:0] starve_cnt, starve_cnt_nxt;

    assign force_buf = buf_live && (starve_cnt == STARVE_LIMIT) && wb_valid;

    // The counter only measures losses of a live entry; any exit clears it.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!buf_live || grant_buf || squash) begin
            starve_cnt_nxt = 3'd0;
        end else if (grant_wb && starve_cnt != STARVE_LIMIT) begin
            starve_cnt_nxt = starve_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 3'd0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end
`else
    assign force_buf = 1'b0;
`endif

    // Arbitration and buffer next-state.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_nxt = state;
        grant_wb  = 1'b0;
        grant_buf = 1'b0;
        squash    = 1'b0;
        wb_ready  = 1'b1;

        if (force_buf) begin
            wb_ready  = 1'b0;
            grant_buf = 1'b1;
            state_nxt = EMPTY;
        end else if (wb_use) begin
            grant_wb = 1'b1;
            // Newer writeback to the same register makes the buffered value obsolete.
            if (buf_live && buf_dest == wb_dest) begin
                squash    = 1'b1;
                state_nxt = EMPTY;
            end
        end else if (buf_live) begin
            grant_buf = 1'b1;
            state_nxt = EMPTY;
        end

        if (state == FULL && buf_dead) begin
            state_nxt = EMPTY;
        end

        // Capture is only possible from EMPTY; destination 0 is dropped here.
        if (lu_fire && lu_dest != 5'd0) begin
            state_nxt = FULL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed while state is FULL, which reset clears.
    always_ff @(posedge clk) begin
        if (lu_fire) begin
            buf_dest  <= lu_dest;
            buf_wdata <= lu_wdata;
            buf_pc    <= lu_pc;
            buf_dead  <= wb_use && (wb_dest == lu_dest);
        end
    end

    // Registered write toward the register file; fields hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
            rf_pc    <= 32'd0;
        end else if (grant_wb) begin
            rf_we    <= 1'b1;
            rf_waddr <= wb_dest;
            rf_wdata <= wb_wdata;
            rf_pc    <= wb_pc;
        end else if (grant_buf) begin
            rf_we    <= 1'b1;
            rf_waddr <= buf_dest;
            rf_wdata <= buf_wdata;
            rf_pc    <= buf_pc;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    assign fwd_bus           = {rf_we, rf_waddr, rf_wdata};
    assign debug_wb_pc       = rf_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_rf_wport_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_dest;
    logic [31:0] wb_wdata, wb_pc;
    logic        wb_ready;
    logic        lu_valid;
    logic [4:0]  lu_dest;
    logic [31:0] lu_wdata, lu_pc;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [37:0] fwd_bus;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest),
        .wb_wdata(wb_wdata), .wb_pc(wb_pc), .wb_ready(wb_ready),
        .lu_valid(lu_valid), .lu_dest(lu_dest), .lu_wdata(lu_wdata),
        .lu_pc(lu_pc), .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_bus(fwd_bus), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] pc;
        bit          dead;
    } entry_t;

    entry_t      m_q[$];   // at most one pending long-latency result
    int          m_losses; // consecutive cycles the pending entry lost to writeback
    bit          e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_pc;

    function automatic bit model_live();
        return (m_q.size() == 1) && !m_q[0].dead;
    endfunction

    function automatic bit model_force();
`ifdef RF_ARB_STARVE_EN
        return model_live() && (m_losses == SMAX) && wb_valid;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_wb_ready();
        return !model_force();
    endfunction

    function automatic bit exp_lu_ready();
        return (m_q.size() == 0) && !reset;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_losses = 0;
        e_we = 0; e_waddr = '0; e_wdata = '0; e_pc = '0;
    endtask

    // Applies one clock edge worth of the arbitration rules to the model.
    task automatic model_update();
        bit wb_use, live, forced, capture;
        wb_use  = wb_valid && wb_we && (wb_dest != 0);
        live    = model_live();
        forced  = model_force();
        capture = lu_valid && (m_q.size() == 0);
        e_we = 0;
        if (forced) begin
            e_we = 1; e_waddr = m_q[0].dest; e_wdata = m_q[0].data; e_pc = m_q[0].pc;
            m_q.delete(); m_losses = 0;
        end else if (wb_use) begin
            e_we = 1; e_waddr = wb_dest; e_wdata = wb_wdata; e_pc = wb_pc;
            if (live) begin
                if (m_q[0].dest == wb_dest) begin
                    m_q.delete(); m_losses = 0;
                end else if (m_losses < SMAX) begin
                    m_losses++;
                end
            end
        end else if (live) begin
            e_we = 1; e_waddr = m_q[0].dest; e_wdata = m_q[0].data; e_pc = m_q[0].pc;
            m_q.delete(); m_losses = 0;
        end
        if (m_q.size() == 1 && m_q[0].dead) begin
            m_q.delete(); m_losses = 0;
        end
        if (capture && lu_dest != 0) begin
            m_q.push_back('{dest: lu_dest, data: lu_wdata, pc: lu_pc,
                            dead: wb_use && (wb_dest == lu_dest)});
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wb_valid = 0; wb_we = 0; wb_dest = '0; wb_wdata = '0; wb_pc = '0;
        lu_valid = 0; lu_dest = '0; lu_wdata = '0; lu_pc = '0;
    endtask

    task automatic drive_lu(input logic [4:0] d, input logic [31:0] data, input logic [31:0] pc);
        lu_valid = 1; lu_dest = d; lu_wdata = data; lu_pc = pc;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] d, input logic [31:0] data, input logic [31:0] pc);
        wb_valid = 1; wb_we = we; wb_dest = d; wb_wdata = data; wb_pc = pc;
    endtask

    function automatic logic [69:0] obs_write();
        return {rf_we, rf_waddr, rf_wdata, debug_wb_pc};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [69:0] all_out;
        reset = 1;
        set_idle();
        #3;
        all_out = obs_write();
        checks++;
        if (all_out !== 70'd0 || fwd_bus !== 38'd0 || debug_wb_rf_we !== 4'd0) begin
            errors++; $display("FAIL reset_outputs: got %h fwd %h dbg_we %h, want 0", all_out, fwd_bus, debug_wb_rf_we);
        end
        checks++;
        if (wb_ready !== 1'b1 || lu_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got wb_ready %b lu_ready %b, want 1 0", wb_ready, lu_ready);
        end
        repeat (2) @(posedge clk);
        #1 reset = 0;
        model_reset();

        // Put a write in flight with a buffered entry pending, then reset mid-cycle.
        drive_lu(5'd12, 32'hDEAD_0012, 32'h0000_1200);
        tick();
        set_idle();
        drive_wb(1'b1, 5'd3, 32'h0000_0033, 32'h0000_0300);
        tick();
        set_idle();
        checks++;
        if (rf_we !== 1'b1 || lu_ready !== 1'b0) begin
            errors++; $display("FAIL reset_precond: got rf_we %b lu_ready %b, want 1 0", rf_we, lu_ready);
        end
        #2 reset = 1;
        #1;
        model_reset();
        all_out = obs_write();
        checks++;
        if (all_out !== 70'd0 || fwd_bus !== 38'd0 || debug_wb_rf_wnum !== 5'd0 || debug_wb_rf_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_async: got %h fwd %h, want 0", all_out, fwd_bus);
        end
        checks++;
        if (wb_ready !== 1'b1 || lu_ready !== 1'b0) begin
            errors++; $display("FAIL reset_async_ready: got wb_ready %b lu_ready %b, want 1 0", wb_ready, lu_ready);
        end
        @(posedge clk);
        #3 reset = 0;
        tick();
        checks++;
        if (lu_ready !== 1'b1 || rf_we !== 1'b0) begin
            errors++; $display("FAIL reset_release: got lu_ready %b rf_we %b, want 1 0", lu_ready, rf_we);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rf_we !== 1'b0) begin
                errors++; $display("FAIL reset_dropped_entry: got rf_we %b waddr %0d, want 0", rf_we, rf_waddr);
            end
        end
    endtask

    task automatic test_single_lu();
        drive_lu(5'd5, 32'h0000_1234, 32'h0000_5000);
        checks++;
        if (lu_ready !== 1'b1) begin
            errors++; $display("FAIL lu_ready_idle: got %b want 1", lu_ready);
        end
        tick();
        set_idle();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL lu_latency_early: got rf_we %b want 0 one cycle after handshake", rf_we);
        end
        tick();
        checks++;
        if (obs_write() !== {1'b1, 5'd5, 32'h0000_1234, 32'h0000_5000}) begin
            errors++; $display("FAIL lu_write: got %h want %h", obs_write(), {1'b1, 5'd5, 32'h0000_1234, 32'h0000_5000});
        end
        checks++;
        if (fwd_bus !== {1'b1, 5'd5, 32'h0000_1234} || debug_wb_rf_we !== 4'hF ||
            debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 32'h0000_1234) begin
            errors++; $display("FAIL lu_fanout: got fwd %h dbg_we %h wnum %0d wdata %h", fwd_bus, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h0000_1234) begin
            errors++; $display("FAIL lu_hold: got we %b addr %0d data %h, want 0 5 1234", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_starvation();
        drive_lu(5'd7, 32'h0000_7777, 32'h0000_7000);
        tick();
        set_idle();
`ifdef RF_ARB_STARVE_EN
        for (int k = 1; k <= SMAX + 1; k++) begin
            drive_wb(1'b1, 5'd3, 32'h3000_0000 + k, 32'h0000_3000);
            checks++;
            if (wb_ready !== (k <= SMAX)) begin
                errors++; $display("FAIL starve_ready_%0d: got %b want %b", k, wb_ready, (k <= SMAX));
            end
            tick();
            checks++;
            if (k <= SMAX && (rf_we !== 1'b1 || rf_waddr !== 5'd3)) begin
                errors++; $display("FAIL starve_wb_%0d: got we %b addr %0d, want 1 3", k, rf_we, rf_waddr);
            end else if (k > SMAX && obs_write() !== {1'b1, 5'd7, 32'h0000_7777, 32'h0000_7000}) begin
                errors++; $display("FAIL starve_force: got %h want dest 7 data 7777", obs_write());
            end
        end
        set_idle();
`else
        for (int k = 1; k <= SMAX + 2; k++) begin
            drive_wb(1'b1, 5'd3, 32'h3000_0000 + k, 32'h0000_3000);
            checks++;
            if (wb_ready !== 1'b1) begin
                errors++; $display("FAIL nostarve_ready_%0d: got %b want 1", k, wb_ready);
            end
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
                errors++; $display("FAIL nostarve_wb_%0d: got we %b addr %0d, want 1 3", k, rf_we, rf_waddr);
            end
        end
        set_idle();
        tick();
        checks++;
        if (obs_write() !== {1'b1, 5'd7, 32'h0000_7777, 32'h0000_7000}) begin
            errors++; $display("FAIL nostarve_drain: got %h want dest 7 data 7777", obs_write());
        end
`endif
        tick();
    endtask

    task automatic test_waw();
        drive_lu(5'd9, 32'h0000_AAAA, 32'h0000_9000);
        tick();
        set_idle();
        drive_wb(1'b1, 5'd9, 32'h0000_BBBB, 32'h0000_9100);
        tick();
        set_idle();
        checks++;
        if (obs_write() !== {1'b1, 5'd9, 32'h0000_BBBB, 32'h0000_9100} || lu_ready !== 1'b1) begin
            errors++; $display("FAIL waw_squash: got %h lu_ready %b, want dest 9 data BBBB ready 1", obs_write(), lu_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (rf_we !== 1'b0) begin
                errors++; $display("FAIL waw_stale: got rf_we %b data %h, want 0", rf_we, rf_wdata);
            end
        end
        // Capture coinciding with a same-destination writeback.
        drive_lu(5'd14, 32'h0000_DEAD, 32'h0000_E000);
        drive_wb(1'b1, 5'd14, 32'h0000_0E0E, 32'h0000_E100);
        tick();
        set_idle();
        checks++;
        if (rf_we !== 1'b1 || rf_wdata !== 32'h0000_0E0E || lu_ready !== 1'b0) begin
            errors++; $display("FAIL waw_same_cycle: got we %b data %h lu_ready %b, want 1 0E0E 0", rf_we, rf_wdata, lu_ready);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || lu_ready !== 1'b1) begin
            errors++; $display("FAIL waw_dead: got we %b lu_ready %b, want 0 1", rf_we, lu_ready);
        end
    endtask

    task automatic test_wb_nowrite();
        drive_lu(5'd11, 32'h0000_CCCC, 32'h0000_B000);
        tick();
        set_idle();
        drive_wb(1'b0, 5'd11, 32'h0000_1111, 32'h0000_B100);
        checks++;
        if (wb_ready !== 1'b1) begin
            errors++; $display("FAIL nowrite_ready: got %b want 1", wb_ready);
        end
        tick();
        set_idle();
        checks++;
        if (obs_write() !== {1'b1, 5'd11, 32'h0000_CCCC, 32'h0000_B000}) begin
            errors++; $display("FAIL nowrite_drain: got %h want dest 11 data CCCC", obs_write());
        end
        drive_lu(5'd13, 32'h0000_DDDD, 32'h0000_D000);
        tick();
        set_idle();
        drive_wb(1'b1, 5'd0, 32'h0000_2222, 32'h0000_D100);
        tick();
        set_idle();
        checks++;
        if (obs_write() !== {1'b1, 5'd13, 32'h0000_DDDD, 32'h0000_D000}) begin
            errors++; $display("FAIL dest0wb_drain: got %h want dest 13 data DDDD", obs_write());
        end
    endtask

    task automatic test_lu_dest0();
        tick();
        drive_lu(5'd0, 32'h0000_5555, 32'h0000_0F00);
        tick();
        set_idle();
        checks++;
        if (lu_ready !== 1'b1 || rf_we !== 1'b0) begin
            errors++; $display("FAIL lu_dest0_ready: got lu_ready %b rf_we %b, want 1 0", lu_ready, rf_we);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL lu_dest0_write: got rf_we %b want 0", rf_we);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            wb_valid = ($urandom_range(0, 9) < 7);
            wb_we    = ($urandom_range(0, 3) != 0);
            wb_dest  = 5'($urandom_range(0, 7));
            wb_wdata = $urandom;
            wb_pc    = $urandom;
            lu_valid = ($urandom_range(0, 2) == 0);
            lu_dest  = 5'($urandom_range(0, 7));
            lu_wdata = $urandom;
            lu_pc    = $urandom;
            #1;
            checks++;
            if (wb_ready !== exp_wb_ready() || lu_ready !== exp_lu_ready()) begin
                errors++; $display("FAIL rand_ready cycle %0d: got wb %b lu %b, want wb %b lu %b", i, wb_ready, lu_ready, exp_wb_ready(), exp_lu_ready());
            end
            tick();
            checks++;
            if (obs_write() !== {e_we, e_waddr, e_wdata, e_pc} ||
                fwd_bus !== {e_we, e_waddr, e_wdata} || debug_wb_rf_we !== {4{e_we}} ||
                debug_wb_rf_wnum !== e_waddr || debug_wb_rf_wdata !== e_wdata) begin
                errors++; $display("FAIL rand_write cycle %0d: got %h want %h", i, obs_write(), {e_we, e_waddr, e_wdata, e_pc});
            end
        end
        set_idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_lu();
        test_starvation();
        test_waw();
        test_wb_nowrite();
        test_lu_dest0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
